axi4lite_reg_slave: RTL

AXI4-Lite slave register file with NUM_REGS software-visible registers, byte-strobed writes and single-beat reads. It is the endpoint our AXI4-Lite protocol checker monitors: it consumes master requests and produces the B and R responses the checker validates. It never returns EXOKAY, and it returns SLVERR for out-of-range addresses.

---
 rtl/axi4lite_pkg.sv | 31 +++
 rtl/axi4lite_aw_w_join.sv | 67 ++++++
 rtl/axi4lite_reg_slave.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the byte-lane merge
// used when a strobed write lands on an existing register word.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  // Operates on the widest legal bus; narrower callers zero-extend and truncate.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MAX_STRB_WIDTH; b++) begin
      if (strb[b]) begin
        merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4lite_aw_w_join.sv
// Holds one write address and one write data beat independently, so AW and W
// may arrive in either order; presents them together once both slots are full.
module axi4lite_aw_w_join #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [STRB_WIDTH-1:0] w_strb,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic                  commit,
  output logic                  join_valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic [STRB_WIDTH-1:0] strb
);

  logic aw_full;
  logic w_full;

  assign join_valid = aw_full && w_full;

  // Ready is the registered inverse of the slot, so it stays low through reset
  // and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full  <= 1'b0;
      aw_ready <= 1'b0;
      addr     <= '0;
    end else if (commit) begin
      aw_full  <= 1'b0;
      aw_ready <= 1'b1;
    end else if (aw_valid && aw_ready) begin
      aw_full  <= 1'b1;
      aw_ready <= 1'b0;
      addr     <= aw_addr;
    end else begin
      aw_ready <= !aw_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_full  <= 1'b0;
      w_ready <= 1'b0;
      data    <= '0;
      strb    <= '0;
    end else if (commit) begin
      w_full  <= 1'b0;
      w_ready <= 1'b1;
    end else if (w_valid && w_ready) begin
      w_full  <= 1'b1;
      w_ready <= 1'b0;
      data    <= w_data;
      strb    <= w_strb;
    end else begin
      w_ready <= !w_full;
    end
  end

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register file: NUM_REGS byte-strobed registers, SLVERR on any
// address whose word index falls outside the array.
module axi4lite_reg_slave
  import axi4lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  join_valid;
  logic [ADDR_WIDTH-1:0] join_addr;
  logic [DATA_WIDTH-1:0] join_data;
  logic [STRB_WIDTH-1:0] join_strb;
  logic                  commit;

  logic                  b_valid;
  axi_resp_e             b_resp;
  logic                  ar_ready;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  axi_resp_e             r_resp;

  logic [IDX_WIDTH-1:0]  wr_idx;
  logic [IDX_WIDTH-1:0]  rd_idx;
  logic                  wr_hit;
  logic                  rd_hit;

  logic [MAX_DATA_WIDTH-1:0] old_wide;
  logic [MAX_DATA_WIDTH-1:0] new_wide;
  logic [MAX_STRB_WIDTH-1:0] strb_wide;
  logic [MAX_DATA_WIDTH-1:0] merged_wide;
  logic [DATA_WIDTH-1:0]     merged;

  logic unused;

  axi4lite_aw_w_join #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_join (
    .clk        (ACLK),
    .rst_n      (ARESETn),
    .aw_addr    (AWADDR),
    .aw_valid   (AWVALID),
    .aw_ready   (AWREADY),
    .w_data     (WDATA),
    .w_strb     (WSTRB),
    .w_valid    (WVALID),
    .w_ready    (WREADY),
    .commit     (commit),
    .join_valid (join_valid),
    .addr       (join_addr),
    .data       (join_data),
    .strb       (join_strb)
  );

  // A pending B response blocks the next commit so BRESP never changes under VALID.
  assign commit = join_valid && !b_valid;

  // The full upper address field must be zero above the index bits to count as a hit.
  assign wr_idx = join_addr[ADDR_LSB +: IDX_WIDTH];
  assign rd_idx = ARADDR[ADDR_LSB +: IDX_WIDTH];
  assign wr_hit = (join_addr[ADDR_WIDTH-1:ADDR_LSB+IDX_WIDTH] == '0);
  assign rd_hit = (ARADDR[ADDR_WIDTH-1:ADDR_LSB+IDX_WIDTH] == '0);

  always_comb begin
    old_wide  = '0;
    new_wide  = '0;
    strb_wide = '0;
    old_wide[DATA_WIDTH-1:0]  = regs[wr_idx];
    new_wide[DATA_WIDTH-1:0]  = join_data;
    strb_wide[STRB_WIDTH-1:0] = join_strb;
    merged_wide = byte_merge(old_wide, new_wide, strb_wide);
  end

  assign merged = merged_wide[DATA_WIDTH-1:0];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      b_valid  <= 1'b0;
      b_resp   <= RESP_OKAY;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (b_valid && BREADY) begin
        b_valid <= 1'b0;
      end
      if (commit) begin
        b_valid <= 1'b1;
        if (wr_hit) begin
          regs[wr_idx]     <= merged;
          wr_pulse[wr_idx] <= 1'b1;
          b_resp           <= RESP_OKAY;
        end else begin
          b_resp <= RESP_SLVERR;
        end
      end
    end
  end

  // Read capture sees the pre-commit register value when both land on one edge.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_resp   <= RESP_OKAY;
    end else if (ARVALID && ar_ready) begin
      ar_ready <= 1'b0;
      r_valid  <= 1'b1;
      r_data   <= rd_hit ? regs[rd_idx] : '0;
      r_resp   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (r_valid) begin
      if (RREADY) begin
        r_valid  <= 1'b0;
        ar_ready <= 1'b1;
      end
    end else begin
      ar_ready <= 1'b1;
    end
  end

  assign BVALID  = b_valid;
  assign BRESP   = b_resp;
  assign ARREADY = ar_ready;
  assign RVALID  = r_valid;
  assign RDATA   = r_data;
  assign RRESP   = r_resp;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  assign unused = ^{AWPROT, ARPROT, join_addr, ARADDR, merged_wide};

endmodule
